// File: rtl/div_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_controller: RV32M DIV/DIVU/REM/REMU sequencer for the iterative      |
// | divider. Optional timeout: define DIV_CTRL_TIMEOUT_EN. Revision: 1.0     |
// +--------------------------------------------------------------------------+
module div_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic [31:0] div_remainder,
  input  logic        div_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic        r_split;
  logic        r_pend;

  logic        w_accept;
  logic        w_imm;
  logic        w_split;
  logic [31:0] w_imm_result;
  logic [31:0] w_r2;
  logic [31:0] w_q2;
  logic [31:0] w_fix_result;
  logic        w_timeout;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready && !cancel;
  assign resp_valid = (r_state == S_DONE) && !cancel;
  assign resp_data = r_result;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign div_start = (r_state == S_START) && !cancel && !w_timeout;

  // Cases answered without the divider; anything else is a divider request.
  always_comb begin
    w_imm        = 1'b1;
    w_split      = 1'b0;
    w_imm_result = 32'd0;
    if (req_b == 32'd0) begin
      w_imm_result = req_op[1] ? req_a : 32'hFFFF_FFFF;
    end else if (!req_op[0] && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
      w_imm_result = req_op[1] ? 32'd0 : 32'h8000_0000;
    end else if (req_op[0] && req_b[31]) begin
      if (req_a >= req_b) w_imm_result = req_op[1] ? (req_a - req_b) : 32'd1;
      else                w_imm_result = req_op[1] ? req_a : 32'd0;
    end else begin
      w_imm   = 1'b0;
      w_split = req_op[0] && req_a[31];
    end
  end

  // Split path: the divider saw a>>1, so finish with one restoring step on a[0].
  always_comb begin
    w_r2 = {r_rem[30:0], r_a[0]};
    w_q2 = {r_q[30:0], 1'b0};
    if (w_r2 >= r_b) begin
      w_r2 = w_r2 - r_b;
      w_q2 = w_q2 + 32'd1;
    end
    if (r_split)       w_fix_result = r_op[1] ? w_r2 : w_q2;
    else if (!r_op[0]) w_fix_result = r_op[1] ? (r_a[31] ? (32'd0 - r_rem) : r_rem) : r_q;
    else               w_fix_result = r_op[1] ? r_rem : r_q;
  end

`ifdef DIV_CTRL_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;
  logic               w_cnt_state;

  assign w_cnt_state = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_timeout   = w_cnt_state && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err    = r_err && (r_state == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_cnt_state && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                           r_cnt <= '0;
      if (w_accept)                         r_err <= 1'b0;
      else if (w_timeout && w_next == S_DONE) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_imm)         w_next = S_DONE;
          else if (div_busy) w_next = S_DRAIN;
          else               w_next = S_START;
        end
      end
      S_START: begin
        if (cancel)        w_next = S_DRAIN;
        else if (div_busy) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (cancel)         w_next = S_DRAIN;
        else if (!div_busy) w_next = S_FIX;
      end
      S_FIX:   w_next = cancel ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_DRAIN: begin
        // A pending request parked here behind a stale divider operation.
        if (!div_busy) w_next = (r_pend && !cancel) ? S_START : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = (r_state == S_DRAIN || cancel) ? S_IDLE : S_DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_q      <= 32'd0;
      r_rem    <= 32'd0;
      r_result <= 32'd0;
      r_div_a  <= 32'd0;
      r_div_b  <= 32'd0;
      r_split  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= req_op;
        r_a     <= req_a;
        r_b     <= req_b;
        r_split <= w_split;
        r_pend  <= !w_imm && div_busy;
        if (w_imm) begin
          r_result <= w_imm_result;
        end else begin
          r_div_a <= w_split ? {1'b0, req_a[31:1]} : req_a;
          r_div_b <= req_b;
        end
      end
      if (r_state == S_DRAIN && w_next != S_DRAIN) r_pend <= 1'b0;
      if (r_state == S_WAIT && w_next == S_FIX) begin
        r_q   <= div_result;
        r_rem <= div_remainder;
      end
      if (r_state == S_FIX && w_next == S_DONE) r_result <= w_fix_result;
      if (w_timeout && w_next == S_DONE)        r_result <= 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_controller: directed bench with a behavioural divider model and   |
// | a response scoreboard. Revision: 1.0                                     |
// +--------------------------------------------------------------------------+
module tb_div_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        cancel = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_result = 32'd0;
  logic [31:0] div_remainder = 32'd0;
  logic        div_busy = 1'b0;

  always #5 clock = ~clock;

  div_controller #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .cancel(cancel),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_remainder(div_remainder), .div_busy(div_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Divider model: returns the vector's q/r after m_lat busy cycles.
  logic [31:0] m_q = 32'd0, m_r = 32'd0, m_seen_a = 32'd0, m_seen_b = 32'd0;
  int          m_lat = 3;
  int          m_cnt = 0;
  int          n_starts = 0;
  bit          m_stuck = 1'b0;
  bit          m_ignore = 1'b0;

  always @(posedge clock) begin
    if (div_busy) begin
      if (!m_stuck) begin
        if (m_cnt <= 1) begin
          div_busy      <= 1'b0;
          div_result    <= m_q;
          div_remainder <= m_r;
        end
        m_cnt <= m_cnt - 1;
      end
    end else if (div_start && !m_ignore) begin
      div_busy <= 1'b1;
      m_cnt    <= m_lat;
      m_seen_a <= div_a;
      m_seen_b <= div_b;
      n_starts <= n_starts + 1;
    end
  end

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got data %h err %b expected no response", resp_data, resp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_data", {1'b0, resp_data}, {1'b0, e[31:0]});
        check("resp_err", {32'd0, resp_err}, {32'd0, e[32]});
      end
    end
  end

  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                        input logic [31:0] exp, input bit imm, input logic [31:0] exp_div_a);
    int  starts0;
    int  cyc;
    bit  rdy_bad;
    m_q = q;
    m_r = r;
    starts0 = n_starts;
    @(negedge clock);
    check({name, "_ready"}, {32'd0, req_ready}, 33'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    exp_q.push_back({1'b0, exp});
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0; rdy_bad = 1'b0;
    do begin
      @(negedge clock);
      cyc++;
      if (req_ready) rdy_bad = 1'b1;
    end while (!resp_valid && cyc < 200);
    check({name, "_responded"}, {32'd0, resp_valid}, 33'd1);
    if (!resp_valid) exp_q.delete();
    check({name, "_busy_ready"}, {32'd0, rdy_bad}, 33'd0);
    if (imm) begin
      check({name, "_latency"}, 33'(cyc), 33'd1);
      check({name, "_no_start"}, 33'(n_starts - starts0), 33'd0);
    end else begin
      check({name, "_div_a"}, {1'b0, m_seen_a}, {1'b0, exp_div_a});
      check({name, "_div_b"}, {1'b0, m_seen_b}, {1'b0, b});
    end
    @(negedge clock);
    check({name, "_ready_after"}, {32'd0, req_ready}, 33'd1);
  endtask

  initial begin
    int  cyc;
    bit  flag;
    repeat (3) @(negedge clock);
    check("rst_ready", {32'd0, req_ready}, 33'd1);
    check("rst_resp_valid", {32'd0, resp_valid}, 33'd0);
    check("rst_resp_data", {1'b0, resp_data}, 33'd0);
    check("rst_resp_err", {32'd0, resp_err}, 33'd0);
    check("rst_div_start", {32'd0, div_start}, 33'd0);
    check("rst_div_a", {1'b0, div_a}, 33'd0);
    check("rst_div_b", {1'b0, div_b}, 33'd0);
    reset = 1'b0;

    do_req("div_7_2",     2'b00, 32'd7,          32'd2,          32'd3,          32'd1, 32'd3,          0, 32'd7);
    do_req("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'd1, 32'hFFFF_FFFF,  0, 32'hFFFF_FFF9);
    do_req("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1, 32'd1,          0, 32'd7);
    do_req("div_by0",     2'b00, 32'd5,          32'd0,          32'd0,          32'd0, 32'hFFFF_FFFF,  1, 32'd0);
    do_req("remu_by0",    2'b11, 32'd5,          32'd0,          32'd0,          32'd0, 32'd5,          1, 32'd0);
    do_req("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0, 32'h8000_0000,  1, 32'd0);
    do_req("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0, 32'd0,          1, 32'd0);
    do_req("divu_split",  2'b01, 32'hFFFF_FFFF,  32'd2,          32'h3FFF_FFFF,  32'd1, 32'h7FFF_FFFF,  0, 32'h7FFF_FFFF);
    do_req("remu_split",  2'b11, 32'hFFFF_FFFF,  32'd2,          32'h3FFF_FFFF,  32'd1, 32'd1,          0, 32'h7FFF_FFFF);
    do_req("divu_split3", 2'b01, 32'hF000_0000,  32'd3,          32'h2800_0000,  32'd0, 32'h5000_0000,  0, 32'h7800_0000);
    do_req("remu_split3", 2'b11, 32'hF000_0001,  32'd3,          32'h2800_0000,  32'd0, 32'd1,          0, 32'h7800_0000);
    do_req("divu_bigb",   2'b01, 32'd5,          32'h8000_0000,  32'd0,          32'd0, 32'd0,          1, 32'd0);
    do_req("remu_bigb",   2'b11, 32'd5,          32'h8000_0000,  32'd0,          32'd0, 32'd5,          1, 32'd0);
    do_req("divu_ge",     2'b01, 32'h9000_0000,  32'h8000_0001,  32'd0,          32'd0, 32'd1,          1, 32'd0);
    do_req("remu_ge",     2'b11, 32'h9000_0000,  32'h8000_0001,  32'd0,          32'd0, 32'h0FFF_FFFF,  1, 32'd0);

    // Cancel while the divider is busy: no response, ready held until busy drops.
    m_lat = 5;
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd100; req_b = 32'd7;
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!div_busy && cyc < 20) begin @(negedge clock); cyc++; end
    check("cancel_busy_seen", {32'd0, div_busy}, 33'd1);
    m_stuck = 1'b1;
    @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    flag = 1'b0;
    repeat (10) begin @(negedge clock); if (req_ready || resp_valid) flag = 1'b1; end
    check("cancel_held", {32'd0, flag}, 33'd0);
    m_stuck = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clock); cyc++; end
    check("cancel_ready_back", {32'd0, req_ready}, 33'd1);
    check("cancel_busy_low", {32'd0, div_busy}, 33'd0);

    // Reset mid-operation: the next request waits out the stale divider op.
    m_lat = 20;
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd50; req_b = 32'd5;
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!div_busy && cyc < 20) begin @(negedge clock); cyc++; end
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ready", {32'd0, req_ready}, 33'd1);
    reset = 1'b0;
    do_req("after_rst", 2'b01, 32'd40, 32'd6, 32'd6, 32'd4, 32'd6, 0, 32'd40);
    m_lat = 3;

`ifdef DIV_CTRL_TIMEOUT_EN
    m_ignore = 1'b1;
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd3;
    exp_q.push_back({1'b1, 32'd0});
    @(posedge clock);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!resp_valid && cyc < 100);
    check("timeout_resp", {32'd0, resp_valid}, 33'd1);
    if (!resp_valid) exp_q.delete();
    check("timeout_cycles", 33'(cyc), 33'd65);
    m_ignore = 1'b0;
    @(negedge clock);
`endif

    repeat (3) @(negedge clock);
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_controller.md
Name: div_controller

Overview:
- Sequencer between the execute stage and the iterative `divider` for RV32M DIV/DIVU/REM/REMU.
- Accepts one request at a time and answers the architectural special cases (divide-by-zero, signed overflow) directly.
- For all other cases, drives the divider's start/busy handshake, then fixes up remainder sign and unsigned large operands.
- Returns one 32-bit result with a one-cycle valid pulse.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles waiting on div_busy (used only with the optional feature).

Ports:
- clock  in  1  system clock, posedge logic
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  2  funct3[1:0]: bit0=unsigned, bit1=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- req_a  in  32  dividend
- req_b  in  32  divisor
- cancel  in  1  pipeline flush; drop the in-flight request
- resp_valid  out  1  one-cycle result pulse
- resp_data  out  32  result
- resp_err  out  1  timeout flag (optional feature; else tied 0)
- div_start  out  1  to divider start
- div_a  out  32  to divider a
- div_b  out  32  to divider b
- div_result  in  32  divider quotient
- div_remainder  in  32  divider unsigned-magnitude remainder
- div_busy  in  1  divider busy

Behaviour:
- Reset (async, active-high):
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_data=0, resp_err=0.
  - div_start=0, div_a=0, div_b=0.
  - All internal registers cleared.
- Handshake: accept on the posedge where req_valid && req_ready; latch op, a and b.
- States: IDLE, START, WAIT, FIX, DONE, DRAIN.
- IDLE, on accept:
  - b==0: result = 0xFFFFFFFF for DIV/DIVU, a for REM/REMU; go to DONE (latency 1).
  - Signed op with a==0x80000000 and b==0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM; go to DONE.
  - Unsigned op with b[31]=1: q = (a>=b), r = a - (q ? b : 0); go to DONE.
  - Unsigned op with a[31]=1, b[31]=0: split path; div_a = a>>1, div_b = b; go to START.
  - Otherwise: div_a = a, div_b = b; go to START.
- START: div_start=1; hold until div_busy is sampled 1, then div_start=0 and go to WAIT.
- WAIT: when div_busy is sampled 0, capture div_result/div_remainder and go to FIX.
- FIX (1 cycle):
  - Signed REM: result = a[31] ? -rem : rem.
  - Signed DIV: result = quotient (the divider applies the quotient sign).
  - Unsigned normal: result = quotient or rem.
  - Split path: r2 = {rem[30:0], a[0]}, q2 = {q[30:0], 1'b0}; if r2 >= b then r2 -= b and q2 += 1; result = q2 or r2.
  - All arithmetic is 32-bit modulo 2^32.
- DONE: resp_valid=1 and resp_data=result for exactly one cycle, then IDLE. resp_data holds its value until the next response.
- Cancel:
  - In IDLE, DONE or FIX: the DONE/FIX response is suppressed and state goes to IDLE.
  - In START or WAIT: go to DRAIN with div_start=0.
  - DRAIN: wait until div_start is deasserted and div_busy is sampled 0, then go to IDLE with no response.
  - A cancel in the same cycle as accept wins: nothing is accepted.
- Reset mid-operation: immediate return to IDLE. The divider is not reset, so the first request after reset passes through DRAIN if div_busy=1.
- req_ready stays low in every state except IDLE. No back-to-back overlap.

Optional Feature:
- Macro: DIV_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in START, WAIT and DRAIN.
  - When it reaches TIMEOUT_CYCLES: div_start=0, resp_valid=1, resp_err=1, resp_data=0, then IDLE.
  - A timeout in DRAIN returns to IDLE silently.
- Undefined: no counter; resp_err is constant 0; the controller waits indefinitely.

Test Plan:
- DIV a=7, b=2, divider model returns q=3 r=1 -> resp_data=3, one-cycle resp_valid, req_ready low until after DONE.
- REM a=0xFFFFFFF9 (-7), b=2 -> divider model returns r=1 -> resp_data=0xFFFFFFFF (-1).
- DIV 5/0 -> resp_data=0xFFFFFFFF; REMU 5/0 -> 5; both one cycle after accept, div_start never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; no divider activity.
- DIVU 0xFFFFFFFF/2 -> div_a=0x7FFFFFFF, model q=0x3FFFFFFF r=1 -> resp_data=0x7FFFFFFF; REMU same -> 1. DIVU 5/0x80000000 -> 0; REMU -> 5.
- Cancel asserted in WAIT with div_busy=1 -> no resp_valid, req_ready=0 until div_busy falls. With DIV_CTRL_TIMEOUT_EN and div_busy stuck 0 -> resp_err=1 after 64 cycles.
